// File: rtl/cnn_frame_sequencer.sv
// Multi-channel feature-map sequencer: vsync/hsync blanking then a width x height data phase per channel.
// Start-to-VSYNC latency 1 cycle; i_stall freezes the DATA phase only, blanking phases ignore it.
module cnn_frame_sequencer #(
  parameter int W_SIZE       = 12,
  parameter int W_DELAY      = 12,
  parameter int W_CH         = 8,
  parameter int W_FRAME_SIZE = 2*W_SIZE+1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_DELAY-1:0]      q_vsync_delay,
  input  logic [W_DELAY-1:0]      q_hsync_delay,
  input  logic [W_CH-1:0]         q_channels,
  input  logic                    q_start,
  input  logic                    i_stall,
  output logic                    o_busy,
  output logic                    o_ctrl_vsync_run,
  output logic                    o_ctrl_hsync_run,
  output logic                    o_ctrl_data_run,
  output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
  output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
  output logic                    o_data_valid,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CH-1:0]         o_channel,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_line,
  output logic                    o_end_frame,
  output logic                    o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_VSYNC = 3'd1;
  localparam logic [2:0] S_HSYNC = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              r_state;
  logic [2:0]              w_next;
  logic [W_SIZE-1:0]       r_width;
  logic [W_DELAY-1:0]      r_vdly;
  logic [W_DELAY-1:0]      r_hdly;
  logic [W_CH-1:0]         r_channels;
  logic [W_FRAME_SIZE-1:0] r_frame_size;
  logic [W_DELAY-1:0]      r_vcnt;
  logic [W_DELAY-1:0]      r_hcnt;
  logic [W_SIZE-1:0]       r_row;
  logic [W_SIZE-1:0]       r_col;
  logic [W_CH-1:0]         r_channel;
  logic [W_FRAME_SIZE-1:0] r_dcnt;

  logic w_data_run;
  logic w_beat;
  logic w_end_line;
  logic w_end_frame;
  logic w_last_ch;
  logic w_zero_cfg;

  assign w_data_run  = (r_state == S_DATA);
  assign w_beat      = w_data_run & ~i_stall;
  assign w_end_line  = w_data_run && (r_col == r_width - W_SIZE'(1));
  assign w_end_frame = w_data_run && (r_dcnt == r_frame_size - W_FRAME_SIZE'(1));
  assign w_last_ch   = (r_channel == r_channels - W_CH'(1));
  assign w_zero_cfg  = (q_width == '0) || (q_height == '0) || (q_channels == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (q_start) w_next = w_zero_cfg ? S_DONE : S_VSYNC;
      S_VSYNC: if (r_vcnt == r_vdly) w_next = S_HSYNC;
      S_HSYNC: if (r_hcnt == r_hdly) w_next = S_DATA;
      S_DATA: begin
        if (w_beat) begin
          if (w_end_frame)     w_next = w_last_ch ? S_DONE : S_VSYNC;
          else if (w_end_line) w_next = S_HSYNC;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_width      <= '0;
      r_vdly       <= '0;
      r_hdly       <= '0;
      r_channels   <= '0;
      r_frame_size <= '0;
      r_vcnt       <= '0;
      r_hcnt       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_channel    <= '0;
      r_dcnt       <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && q_start) begin
        r_width      <= q_width;
        r_vdly       <= q_vsync_delay;
        r_hdly       <= q_hsync_delay;
        r_channels   <= q_channels;
        r_frame_size <= W_FRAME_SIZE'(q_width) * W_FRAME_SIZE'(q_height);
        r_channel    <= '0;
      end
      r_vcnt <= (r_state == S_VSYNC && w_next == S_VSYNC) ? r_vcnt + W_DELAY'(1) : '0;
      r_hcnt <= (r_state == S_HSYNC && w_next == S_HSYNC) ? r_hcnt + W_DELAY'(1) : '0;
      if (w_beat) begin
        if (w_end_frame) begin
          r_row  <= '0;
          r_col  <= '0;
          r_dcnt <= '0;
          if (!w_last_ch) r_channel <= r_channel + W_CH'(1);
        end else if (w_end_line) begin
          r_col  <= '0;
          r_row  <= r_row + W_SIZE'(1);
          r_dcnt <= r_dcnt + W_FRAME_SIZE'(1);
        end else begin
          r_col  <= r_col + W_SIZE'(1);
          r_dcnt <= r_dcnt + W_FRAME_SIZE'(1);
        end
      end
      // Overrides the increment above so the index reads 0 once the run completes.
      if (w_next == S_DONE && r_state != S_DONE) r_channel <= '0;
    end
  end

  assign o_busy           = (r_state != S_IDLE);
  assign o_ctrl_vsync_run = (r_state == S_VSYNC);
  assign o_ctrl_hsync_run = (r_state == S_HSYNC);
  assign o_ctrl_data_run  = w_data_run;
  assign o_ctrl_vsync_cnt = r_vcnt;
  assign o_ctrl_hsync_cnt = r_hcnt;
  assign o_data_valid     = w_beat;
  assign o_row            = r_row;
  assign o_col            = r_col;
  assign o_channel        = r_channel;
  assign o_data_count     = r_dcnt;
  assign o_end_line       = w_end_line;
  assign o_end_frame      = w_end_frame;
  assign o_done           = (r_state == S_DONE);

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: per-cycle capture of each run, checked against hand-derived timelines.
module tb_cnn_frame_sequencer;
  localparam int W_SIZE       = 12;
  localparam int W_DELAY      = 12;
  localparam int W_CH         = 8;
  localparam int W_FRAME_SIZE = 2*W_SIZE+1;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [W_SIZE-1:0]       q_width;
  logic [W_SIZE-1:0]       q_height;
  logic [W_DELAY-1:0]      q_vsync_delay;
  logic [W_DELAY-1:0]      q_hsync_delay;
  logic [W_CH-1:0]         q_channels;
  logic                    q_start;
  logic                    i_stall;
  logic                    o_busy;
  logic                    o_ctrl_vsync_run;
  logic                    o_ctrl_hsync_run;
  logic                    o_ctrl_data_run;
  logic [W_DELAY-1:0]      o_ctrl_vsync_cnt;
  logic [W_DELAY-1:0]      o_ctrl_hsync_cnt;
  logic                    o_data_valid;
  logic [W_SIZE-1:0]       o_row;
  logic [W_SIZE-1:0]       o_col;
  logic [W_CH-1:0]         o_channel;
  logic [W_FRAME_SIZE-1:0] o_data_count;
  logic                    o_end_line;
  logic                    o_end_frame;
  logic                    o_done;

  always #5 clk = ~clk;

  cnn_frame_sequencer #(
    .W_SIZE(W_SIZE), .W_DELAY(W_DELAY), .W_CH(W_CH), .W_FRAME_SIZE(W_FRAME_SIZE)
  ) dut (
    .clk(clk), .rstn(rstn),
    .q_width(q_width), .q_height(q_height),
    .q_vsync_delay(q_vsync_delay), .q_hsync_delay(q_hsync_delay),
    .q_channels(q_channels), .q_start(q_start), .i_stall(i_stall),
    .o_busy(o_busy),
    .o_ctrl_vsync_run(o_ctrl_vsync_run), .o_ctrl_hsync_run(o_ctrl_hsync_run),
    .o_ctrl_data_run(o_ctrl_data_run),
    .o_ctrl_vsync_cnt(o_ctrl_vsync_cnt), .o_ctrl_hsync_cnt(o_ctrl_hsync_cnt),
    .o_data_valid(o_data_valid), .o_row(o_row), .o_col(o_col),
    .o_channel(o_channel), .o_data_count(o_data_count),
    .o_end_line(o_end_line), .o_end_frame(o_end_frame), .o_done(o_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle capture; index = cycles after the start edge. ph = {vsync, hsync, data, done}.
  logic [3:0]  ph    [0:63];
  logic [31:0] col_a [0:63];
  logic [31:0] row_a [0:63];
  logic [31:0] ch_a  [0:63];
  logic [31:0] dc_a  [0:63];
  logic [31:0] vc_a  [0:63];
  logic        el_a  [0:63];
  logic        ef_a  [0:63];
  logic        vld_a [0:63];
  logic        busy_a[0:63];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Phase timeline of width=4 height=2 vsync=2 hsync=1, one channel, start at edge 0.
  function automatic logic [3:0] exp_ph1(input int c);
    if (c >= 1 && c <= 3)        return 4'b1000;
    else if (c >= 4 && c <= 5)   return 4'b0100;
    else if (c >= 6 && c <= 9)   return 4'b0010;
    else if (c >= 10 && c <= 11) return 4'b0100;
    else if (c >= 12 && c <= 15) return 4'b0010;
    else if (c == 16)            return 4'b0001;
    else                         return 4'b0000;
  endfunction

  // Pulses q_start at edge 0, then captures cycles 1..n. Stall covers cycles slo..shi;
  // chg > 0 rewrites q_width at cycle chg and holds q_start for cycles chg..chg+2.
  task automatic run(input int n, input int slo, input int shi, input int chg);
    q_start = 1'b1;
    @(posedge clk); #1;
    q_start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      i_stall = (c >= slo && c <= shi);
      if (chg > 0) begin
        q_start = (c >= chg && c < chg + 3);
        if (c == chg) q_width = 12'd2;
      end
      @(negedge clk);
      ph[c]     = {o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run, o_done};
      col_a[c]  = 32'(o_col);
      row_a[c]  = 32'(o_row);
      ch_a[c]   = 32'(o_channel);
      dc_a[c]   = 32'(o_data_count);
      vc_a[c]   = 32'(o_ctrl_vsync_cnt);
      el_a[c]   = o_end_line;
      ef_a[c]   = o_end_frame;
      vld_a[c]  = o_data_valid;
      busy_a[c] = o_busy;
      @(posedge clk); #1;
    end
    q_start = 1'b0;
    i_stall = 1'b0;
  endtask

  initial begin
    int cnt;
    rstn = 1'b0; q_start = 1'b0; i_stall = 1'b0;
    q_width = 12'd4; q_height = 12'd2; q_vsync_delay = 12'd2; q_hsync_delay = 12'd1;
    q_channels = 8'd1;
    ph[0] = 4'b0000;
    #2;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_runs", 32'({o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run, o_done}), 0);
    chk("rst_pos", 32'({o_row, o_col}), 0);
    chk("rst_cnt", 32'(o_data_count) | 32'(o_ctrl_vsync_cnt) | 32'(o_channel), 0);
    chk("rst_valid", 32'(o_data_valid), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Basic single-channel frame
    run(17, 0, -1, 0);
    for (int c = 1; c <= 17; c++) chk($sformatf("ph1@%0d", c), 32'(ph[c]), 32'(exp_ph1(c)));
    for (int c = 6; c <= 9; c++) chk($sformatf("col1@%0d", c), col_a[c], 32'(c - 6));
    chk("vcnt@3", vc_a[3], 2);
    chk("valid@6", 32'(vld_a[6]), 1);
    chk("eline@8", 32'(el_a[8]), 0);
    chk("eline@9", 32'(el_a[9]), 1);
    chk("eframe@14", 32'(ef_a[14]), 0);
    chk("eframe@15", 32'(ef_a[15]), 1);
    chk("dcnt@15", dc_a[15], 7);
    chk("row@15", row_a[15], 1);
    chk("col@15", col_a[15], 3);
    chk("busy@17", 32'(busy_a[17]), 0);

    // Three channels: 15 stall-free cycles per channel, done one cycle after the last pixel
    q_channels = 8'd3;
    run(48, 0, -1, 0);
    for (int c = 1; c <= 45; c++)
      chk($sformatf("ph3@%0d", c), 32'(ph[c]), 32'(exp_ph1(((c - 1) % 15) + 1)));
    cnt = 0;
    for (int c = 1; c <= 48; c++) cnt += int'(ph[c][0]);
    chk("done_count", 32'(cnt), 1);
    chk("done@46", 32'(ph[46][0]), 1);
    cnt = 0;
    for (int c = 1; c <= 48; c++) cnt += int'(ph[c][3] && !ph[c-1][3]);
    chk("vsync_phases", 32'(cnt), 3);
    chk("ch@7", ch_a[7], 0);
    chk("ch@22", ch_a[22], 1);
    chk("ch@37", ch_a[37], 2);
    chk("ch@47", ch_a[47], 0);
    chk("busy@47", 32'(busy_a[47]), 0);
    q_channels = 8'd1;

    // Stall for cycles 7-9 of the first data row
    run(20, 7, 9, 0);
    for (int c = 7; c <= 9; c++) begin
      chk($sformatf("scol@%0d", c), col_a[c], 1);
      chk($sformatf("svalid@%0d", c), 32'(vld_a[c]), 0);
    end
    chk("scol@10", col_a[10], 1);
    chk("seframe@18", 32'(ef_a[18]), 1);
    chk("sdcnt@18", dc_a[18], 7);
    chk("sdone@16", 32'(ph[16][0]), 0);
    chk("sdone@19", 32'(ph[19][0]), 1);

    // Zero width: straight to DONE
    q_width = 12'd0;
    run(3, 0, -1, 0);
    chk("z_busy@1", 32'(busy_a[1]), 1);
    chk("z_done@1", 32'(ph[1]), 32'(4'b0001));
    chk("z_busy@2", 32'(busy_a[2]), 0);
    chk("z_runs@2", 32'(ph[2]), 0);
    q_width = 12'd4;

    // Width change and start pulses mid-frame are ignored
    run(17, 0, -1, 7);
    chk("c_col@7", col_a[7], 1);
    chk("c_eline@7", 32'(el_a[7]), 0);
    chk("c_eline@9", 32'(el_a[9]), 1);
    chk("c_col@9", col_a[9], 3);
    chk("c_ph@10", 32'(ph[10]), 32'(4'b0100));
    chk("c_done@16", 32'(ph[16]), 32'(4'b0001));
    chk("c_busy@17", 32'(busy_a[17]), 0);
    q_width = 12'd4;

    // Asynchronous reset mid-frame at row 1, col 2 (cycle 14)
    q_start = 1'b1;
    @(posedge clk); #1;
    q_start = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    chk("r_pos", 32'({o_row, o_col}), 32'({12'd1, 12'd2}));
    #1 rstn = 1'b0;
    #1;
    chk("r_busy", 32'(o_busy), 0);
    chk("r_runs", 32'({o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run, o_done}), 0);
    chk("r_pos0", 32'({o_row, o_col}), 0);
    chk("r_dcnt", 32'(o_data_count), 0);
    chk("r_valid", 32'(o_data_valid), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cnt += int'(o_busy) + int'(o_done);
    end
    chk("r_idle", 32'(cnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
